mem_sp_param: RTL and testbench

//  Parametrised single-port synchronous memory; next generation of the 32x8 lab memory.

---
 rtl/mem_sp_param.sv | 149 ++++++++++++++
 tb/tb_mem_sp_param.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_sp_param.sv
// rtl/mem_sp_param.sv - parametrised single-port synchronous memory with init sweep, req handshake and range errors
module mem_sp_param #(
    parameter int                DATA_W     = 8,
    parameter int                DEPTH      = 32,
    parameter int                ADDR_W     = $clog2(DEPTH),
    parameter int                RD_LATENCY = 1,
    parameter logic [DATA_W-1:0] INIT_VAL   = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_in_i,
    output logic              rd_valid_o,
    output logic [DATA_W-1:0] data_out_o,
    output logic              rd_err_o,
    output logic              wr_err_o,
    output logic              init_done_o
);

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    // One extra bit so DEPTH itself is representable when DEPTH is a power of two.
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
    // Any latency other than 1 is treated as the two-stage pipeline.
    localparam bit                TWO_STAGE = (RD_LATENCY != 1);

    state_t              state_q;
    logic [ADDR_W-1:0]   cnt_q;
    logic                req_ready_q;
    logic                init_done_q;
    logic                rd_valid_q;
    logic                rd_err_q;
    logic                wr_err_q;
    logic [DATA_W-1:0]   data_out_q;

    // First stage of the two-cycle read path; idle when RD_LATENCY is 1.
    logic                s1_valid_q;
    logic                s1_err_q;
    logic [DATA_W-1:0]   s1_data_q;

    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                accept;
    logic                addr_ok;
    logic                rd_fire;
    logic [DATA_W-1:0]   rd_word;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;

    // Request decode and the single write port shared by the sweep and user writes.
    always_comb begin
        accept    = req_valid_i & req_ready_q;
        addr_ok   = ({1'b0, addr_i} < DEPTH_X);
        rd_fire   = accept & ~req_write_i;
        rd_word   = addr_ok ? mem_q[addr_i] : '0;
        mem_we    = 1'b0;
        mem_waddr = cnt_q;
        mem_wdata = INIT_VAL;
        if (!rst_i) begin
            if (state_q == ST_INIT) begin
                mem_we = 1'b1;
            end else if (accept && req_write_i && addr_ok) begin
                mem_we    = 1'b1;
                mem_waddr = addr_i;
                mem_wdata = data_in_i;
            end
        end
    end

    // Storage array: no reset, contents are defined by the post-reset sweep.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Control FSM, read pipeline and registered status outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            init_done_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_err_q    <= 1'b0;
            wr_err_q    <= 1'b0;
            data_out_q  <= '0;
            s1_valid_q  <= 1'b0;
            s1_err_q    <= 1'b0;
            s1_data_q   <= '0;
        end else begin
            wr_err_q   <= accept & req_write_i & ~addr_ok;

            s1_valid_q <= rd_fire;
            s1_err_q   <= rd_fire & ~addr_ok;
            if (rd_fire) begin
                s1_data_q <= rd_word;
            end

            if (TWO_STAGE) begin
                rd_valid_q <= s1_valid_q;
                rd_err_q   <= s1_valid_q & s1_err_q;
                if (s1_valid_q) begin
                    data_out_q <= s1_data_q;
                end
            end else begin
                rd_valid_q <= rd_fire;
                rd_err_q   <= rd_fire & ~addr_ok;
                if (rd_fire) begin
                    data_out_q <= rd_word;
                end
            end

            case (state_q)
                ST_INIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        state_q     <= ST_READY;
                        req_ready_q <= 1'b1;
                        init_done_q <= 1'b1;
                    end
                end
                ST_READY: begin
                    req_ready_q <= 1'b1;
                    init_done_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_INIT;
                end
            endcase
        end
    end

    assign req_ready_o = req_ready_q;
    assign init_done_o = init_done_q;
    assign rd_valid_o  = rd_valid_q;
    assign rd_err_o    = rd_err_q;
    assign wr_err_o    = wr_err_q;
    assign data_out_o  = data_out_q;

endmodule

// File: tb/tb_mem_sp_param.sv
// tb/tb_mem_sp_param.sv - scoreboard bench for mem_sp_param across three configurations
module tb_mem_sp_param;

    localparam int NI = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_write;
    logic [4:0] addr;
    logic [7:0] data_in;

    logic       req_ready [NI];
    logic       rd_valid  [NI];
    logic       rd_err    [NI];
    logic       wr_err    [NI];
    logic       init_done [NI];
    logic [7:0] data_out  [NI];

    always #5 clk = ~clk;

    mem_sp_param #(.DATA_W(8), .DEPTH(32), .RD_LATENCY(1)) u_d32_l1 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready[0]),
        .req_write_i(req_write), .addr_i(addr), .data_in_i(data_in),
        .rd_valid_o(rd_valid[0]), .data_out_o(data_out[0]), .rd_err_o(rd_err[0]),
        .wr_err_o(wr_err[0]), .init_done_o(init_done[0])
    );

    mem_sp_param #(.DATA_W(8), .DEPTH(32), .RD_LATENCY(2)) u_d32_l2 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready[1]),
        .req_write_i(req_write), .addr_i(addr), .data_in_i(data_in),
        .rd_valid_o(rd_valid[1]), .data_out_o(data_out[1]), .rd_err_o(rd_err[1]),
        .wr_err_o(wr_err[1]), .init_done_o(init_done[1])
    );

    mem_sp_param #(.DATA_W(8), .DEPTH(24), .ADDR_W(5), .RD_LATENCY(1)) u_d24_l1 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready[2]),
        .req_write_i(req_write), .addr_i(addr), .data_in_i(data_in),
        .rd_valid_o(rd_valid[2]), .data_out_o(data_out[2]), .rd_err_o(rd_err[2]),
        .wr_err_o(wr_err[2]), .init_done_o(init_done[2])
    );

    typedef struct {
        int         cyc;
        bit         wr;
        logic [7:0] data;
        logic       err;
    } exp_t;

    int         dep [NI] = '{32, 32, 24};
    int         lat [NI] = '{1, 2, 1};
    logic [7:0] mem_m [NI][32];
    exp_t       sb [NI][$];

    int cyc     = 0;
    int n_pass  = 0;
    int n_total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int inst, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s[u%0d] observed=%0h expected=%0h at cycle %0d", tag, inst, obs, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < NI; k++) begin
            chk("rd_err_unqualified", k, 32'(rd_err[k] & ~rd_valid[k]), 32'd0);
            if (rd_valid[k] || wr_err[k]) begin
                chk("sb_nonempty", k, 32'(sb[k].size() != 0), 32'd1);
                if (sb[k].size() != 0) begin
                    e = sb[k].pop_front();
                    chk("out_cycle", k, cyc, e.cyc);
                    chk("out_kind", k, 32'({rd_valid[k], wr_err[k]}), e.wr ? 32'd1 : 32'd2);
                    if (!e.wr) begin
                        chk("rd_data", k, 32'(data_out[k]), 32'(e.data));
                        chk("rd_err", k, 32'(rd_err[k]), 32'(e.err));
                    end
                end
            end
        end
    end

    task automatic do_req(input bit w, input int a, input logic [7:0] d);
        exp_t x;
        int   acc;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = w;
        addr      = 5'(a);
        data_in   = d;
        acc       = cyc + 1;
        for (int k = 0; k < NI; k++) begin
            if (w) begin
                if (a < dep[k]) begin
                    mem_m[k][a] = d;
                end else begin
                    x.cyc = acc; x.wr = 1'b1; x.data = 8'h00; x.err = 1'b1;
                    sb[k].push_back(x);
                end
            end else begin
                x.cyc  = acc + lat[k] - 1;
                x.wr   = 1'b0;
                x.data = (a < dep[k]) ? mem_m[k][a] : 8'h00;
                x.err  = (a >= dep[k]);
                sb[k].push_back(x);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
    endtask

    task automatic do_reset(output int r_edge);
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 1'b0;
        for (int k = 0; k < NI; k++) begin
            while (sb[k].size() != 0 && sb[k][sb[k].size()-1].cyc >= cyc + 1) begin
                void'(sb[k].pop_back());
            end
            for (int i = 0; i < 32; i++) mem_m[k][i] = 8'h00;
        end
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk("rst_req_ready", k, 32'(req_ready[k]), 32'd0);
            chk("rst_init_done", k, 32'(init_done[k]), 32'd0);
            chk("rst_rd_valid", k, 32'(rd_valid[k]), 32'd0);
            chk("rst_wr_err", k, 32'(wr_err[k]), 32'd0);
            chk("rst_data_out", k, 32'(data_out[k]), 32'd0);
        end
        rst    = 1'b0;
        r_edge = cyc;
    endtask

    task automatic wait_init(input int r_edge);
        while (cyc < r_edge + 33) begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                if (cyc == r_edge + dep[k] - 1 || cyc == r_edge + dep[k]) begin
                    chk("init_done_edge", k, 32'(init_done[k]), 32'(cyc >= r_edge + dep[k]));
                    chk("req_ready_edge", k, 32'(req_ready[k]), 32'(cyc >= r_edge + dep[k]));
                end
            end
        end
    endtask

    initial begin
        int r;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        addr      = '0;
        data_in   = '0;

        do_reset(r);
        wait_init(r);
        for (int a = 0; a < 32; a++) do_req(1'b0, a, 8'h00);
        idle(3);

        do_req(1'b1, 5, 8'hA5);
        do_req(1'b0, 5, 8'h00);
        idle(3);

        for (int a = 0; a < 4; a++) do_req(1'b1, a, 8'(8'h10 + a));
        for (int a = 0; a < 4; a++) do_req(1'b0, a, 8'h00);
        idle(3);

        do_req(1'b1, 30, 8'h5A);
        idle(2);
        do_req(1'b0, 30, 8'h00);
        do_req(1'b0, 5, 8'h00);
        do_req(1'b1, 31, 8'hC3);
        do_req(1'b0, 31, 8'h00);
        idle(3);

        do_req(1'b0, 5, 8'h00);
        do_reset(r);
        wait_init(r);
        do_req(1'b0, 5, 8'h00);
        idle(3);

        do_reset(r);
        req_valid = 1'b1;
        req_write = 1'b1;
        addr      = 5'd1;
        data_in   = 8'h3C;
        for (int k = 0; k < NI; k++) mem_m[k][1] = 8'h3C;
        wait_init(r);
        req_valid = 1'b0;
        idle(2);
        do_req(1'b0, 1, 8'h00);
        do_req(1'b0, 2, 8'h00);
        idle(4);

        for (int k = 0; k < NI; k++) chk("sb_drained", k, 32'(sb[k].size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
